// File: rtl/fir_seq_pkg.sv
// Shared types and elaboration helpers for the serial FIR sequencer.
// Default coefficient set is a symmetric 40-tap low-pass kernel.
package fir_seq_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} fir_seq_state_t;

  localparam int DEF_NUM_TAPS    = 40;
  localparam int DEF_COEFF_WIDTH = 16;

  typedef logic [$clog2(DEF_NUM_TAPS)-1:0] fir_tap_idx_t;

  localparam logic signed [DEF_COEFF_WIDTH-1:0] DEF_COEFFS [0:DEF_NUM_TAPS-1] = '{
    -16'sd283,  -16'sd858,  -16'sd1082, -16'sd421,  16'sd643,
     16'sd708,  -16'sd430,  -16'sd1101,  16'sd43,   16'sd1473,
     16'sd665,  -16'sd1682, -16'sd1741,  16'sd1510, 16'sd3302,
    -16'sd609,  -16'sd5762, -16'sd2213,  16'sd12277, 16'sd26313,
     16'sd26313, 16'sd12277, -16'sd2213, -16'sd5762, -16'sd609,
     16'sd3302,  16'sd1510, -16'sd1741, -16'sd1682,  16'sd665,
     16'sd1473,  16'sd43,   -16'sd1101, -16'sd430,   16'sd708,
     16'sd643,  -16'sd421,  -16'sd1082, -16'sd858,  -16'sd283
  };

  // Accumulator width that can never overflow for the given coefficient magnitude sum.
  function automatic int calcOutWidthFull(input longint sumAbs, input int inWidth);
    return $clog2(sumAbs) + inWidth;
  endfunction

endpackage

// File: rtl/fir_serial_mac.sv
// Shared signed multiplier with optional output register, feeding a load/accumulate register.
module fir_mac_unit
  import fir_seq_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int ACC_WIDTH    = 33,
  parameter int PIPELINE_MUL = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_first,
  input  logic signed [INPUT_WIDTH-1:0] i_sample,
  input  logic signed [COEFF_WIDTH-1:0] i_coeff,
  output logic signed [ACC_WIDTH-1:0]   o_acc
);

  localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;

  logic signed [PROD_W-1:0]    w_prod;
  logic signed [PROD_W-1:0]    w_accProd;
  logic signed [ACC_WIDTH-1:0] w_accIn;
  logic                        w_accEn;
  logic                        w_accFirst;
  logic signed [ACC_WIDTH-1:0] r_acc;

  assign w_prod  = PROD_W'(i_sample) * PROD_W'(i_coeff);
  assign w_accIn = ACC_WIDTH'(w_accProd);

  if (PIPELINE_MUL != 0) begin : gPipe
    logic signed [PROD_W-1:0] r_mul;
    logic                     r_en;
    logic                     r_first;

    // Enable/first flags travel with the product so the accumulator sees them aligned.
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        r_mul   <= '0;
        r_en    <= 1'b0;
        r_first <= 1'b0;
      end else begin
        r_mul   <= w_prod;
        r_en    <= i_en;
        r_first <= i_first;
      end
    end

    assign w_accProd  = r_mul;
    assign w_accEn    = r_en;
    assign w_accFirst = r_first;
  end else begin : gComb
    assign w_accProd  = w_prod;
    assign w_accEn    = i_en;
    assign w_accFirst = i_first;
  end

  // First product of a sequence loads the accumulator, so no clear cycle is needed.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_acc <= '0;
    end else if (w_accEn) begin
      r_acc <= w_accFirst ? w_accIn : r_acc + w_accIn;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_serial_sequencer.sv
// Serial FIR: one shared MAC walks every tap for each accepted sample.
// The circular delay line keeps full history between samples; only reset clears it.
module fir_serial_sequencer
  import fir_seq_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int COEFF_WIDTH  = DEF_COEFF_WIDTH,
  parameter int NUM_TAPS     = DEF_NUM_TAPS,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [0:NUM_TAPS-1] = DEF_COEFFS,
  parameter int OUTPUT_WIDTH_FULL = 33,
  parameter int OUTPUT_WIDTH      = 33,
  parameter int PIPELINE_MUL      = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid_in,
  input  logic signed [INPUT_WIDTH-1:0]  i_din,
  output logic                           o_ready_in,
  output logic                           o_valid_out,
  output logic signed [OUTPUT_WIDTH-1:0] o_dout,
  output logic                           o_busy
);

  localparam int TAP_W = $clog2(NUM_TAPS);

  typedef logic [TAP_W-1:0] tap_idx_t;

  localparam tap_idx_t       LAST_K = tap_idx_t'(NUM_TAPS - 1);
  localparam logic [TAP_W:0] NT_EXT = (TAP_W + 1)'(NUM_TAPS);

  function automatic longint sumAbsCoeffs();
    longint s = 0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      s += (COEFFS[i] < 0) ? -longint'(COEFFS[i]) : longint'(COEFFS[i]);
    end
    return s;
  endfunction

  if (NUM_TAPS < 2) begin : gBadTaps
    $error("fir_serial_sequencer: NUM_TAPS must be at least 2");
  end
  if (OUTPUT_WIDTH_FULL != calcOutWidthFull(sumAbsCoeffs(), INPUT_WIDTH)) begin : gBadFull
    $error("fir_serial_sequencer: OUTPUT_WIDTH_FULL does not match coefficient magnitude");
  end
  if (OUTPUT_WIDTH > OUTPUT_WIDTH_FULL) begin : gBadOut
    $error("fir_serial_sequencer: OUTPUT_WIDTH exceeds OUTPUT_WIDTH_FULL");
  end

  fir_seq_state_t                 r_state;
  tap_idx_t                       r_wrPtr;
  tap_idx_t                       r_newest;
  tap_idx_t                       r_k;
  tap_idx_t                       w_idx;
  logic signed [INPUT_WIDTH-1:0]  r_buf [0:NUM_TAPS-1];
  logic signed [OUTPUT_WIDTH_FULL-1:0] w_acc;
  logic signed [OUTPUT_WIDTH-1:0] r_dout;
  logic                           r_valid;
  logic                           w_macEn;
  logic                           w_macFirst;

  // Tap k reads the sample k positions older than the newest, wrapping below zero.
  always_comb begin
    w_idx = r_newest - r_k;
    if (r_k > r_newest) begin
      w_idx = tap_idx_t'({1'b0, r_newest} + NT_EXT - {1'b0, r_k});
    end
  end

  assign w_macEn    = (r_state == MAC);
  assign w_macFirst = (r_k == '0);

  fir_mac_unit #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .ACC_WIDTH   (OUTPUT_WIDTH_FULL),
    .PIPELINE_MUL(PIPELINE_MUL)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_macEn),
    .i_first (w_macFirst),
    .i_sample(r_buf[w_idx]),
    .i_coeff (COEFFS[r_k]),
    .o_acc   (w_acc)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= IDLE;
      r_wrPtr  <= '0;
      r_newest <= '0;
      r_k      <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid_in) begin
            r_buf[r_wrPtr] <= i_din;
            r_newest       <= r_wrPtr;
            r_wrPtr        <= (r_wrPtr == LAST_K) ? '0 : r_wrPtr + 1'b1;
            r_k            <= '0;
            r_state        <= MAC;
          end
        end
        MAC: begin
          if (r_k == LAST_K) begin
            r_k <= '0;
            if (PIPELINE_MUL != 0) begin
              r_state <= DRAIN;
            end else begin
              r_state <= OUT;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRAIN: begin
          r_state <= OUT;
        end
        OUT: begin
          r_dout  <= w_acc[OUTPUT_WIDTH_FULL-1 -: OUTPUT_WIDTH];
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready_in  = (r_state == IDLE) && i_rst;
  assign o_busy      = (r_state != IDLE);
  assign o_valid_out = r_valid;
  assign o_dout      = r_dout;

endmodule

// File: tb/tb_fir_serial_sequencer.sv
// Scoreboard bench for fir_serial_sequencer at default parameters: stimulus pushes expected
// results into a queue, a negedge monitor pops and compares on every valid_out pulse.
module tb_fir_serial_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               validIn = 1'b0;
  logic signed [15:0] din = '0;
  logic               readyIn;
  logic               validOut;
  logic signed [32:0] dout;
  logic               busy;

  int errors = 0;
  int checks = 0;

  longint expQ[$];

  int coefHalf [0:19] = '{-283, -858, -1082, -421, 643, 708, -430, -1101, 43, 1473,
                          665, -1682, -1741, 1510, 3302, -609, -5762, -2213, 12277, 26313};
  int coef [0:39];
  logic signed [15:0] hist [0:39];

  always #5 clk = ~clk;

  fir_serial_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid_in (validIn),
    .i_din      (din),
    .o_ready_in (readyIn),
    .o_valid_out(validOut),
    .o_dout     (dout),
    .o_busy     (busy)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Golden model: shift the sample into the history and convolve with the coefficient table.
  function automatic longint modelPush(input logic signed [15:0] s);
    longint acc = 0;
    for (int i = 39; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    for (int k = 0; k < 40; k++) acc += longint'(coef[k]) * longint'(hist[k]);
    return acc;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 40; i++) hist[i] = '0;
  endfunction

  // Offer one sample through the handshake; expected value is either hand-supplied or from the model.
  task automatic applyStimulus(input logic signed [15:0] s, input bit useHand, input longint hand);
    int     waitCyc = 0;
    longint m;
    while (!readyIn && waitCyc < 100) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    if (!readyIn) begin
      checkOutput("readyTimeout", 0, 1);
      return;
    end
    din     = s;
    validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    m = modelPush(s);
    expQ.push_back(useHand ? hand : m);
  endtask

  task automatic waitDrain();
    int cyc = 0;
    while (expQ.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("drainEmpty", expQ.size(), 0);
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (validOut === 1'b1) begin
      if (expQ.size() == 0) checkOutput("unexpectedValid", 1, 0);
      else checkOutput("dout", longint'(dout), expQ.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint sum;
    int     lat;
    int     accepted;
    bit     takeIt;
    logic signed [15:0] v;

    for (int i = 0; i < 40; i++) coef[i] = (i < 20) ? coefHalf[i] : coefHalf[39-i];
    modelClear();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValidOut", longint'(validOut), 0);
    checkOutput("rstDout", longint'(dout), 0);
    checkOutput("rstBusy", longint'(busy), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("readyAfterRst", longint'(readyIn), 1);

    $display("[TB] impulse response");
    for (int n = 0; n < 40; n++)
      applyStimulus((n == 0) ? -16'sd32768 : 16'sd0, 1'b1, longint'(-32768) * longint'(coef[n]));
    waitDrain();

    $display("[TB] step response");
    sum = 0;
    for (int n = 0; n < 42; n++) begin
      if (n < 40) sum += coef[n];
      applyStimulus(-16'sd32768, 1'b1, (n >= 39) ? -64'sd2015363072 : longint'(-32768) * sum);
    end
    waitDrain();

    $display("[TB] latency and handshake");
    din = 16'sd5000; validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    expQ.push_back(modelPush(16'sd5000));
    checkOutput("busyAfterAccept", longint'(busy), 1);
    lat = 0;
    while (!readyIn && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
    checkOutput("readyLowCycles", lat, 42);
    checkOutput("validAtReady", longint'(validOut), 1);
    @(posedge clk); #1;
    checkOutput("validPulseWidth", longint'(validOut), 0);
    waitDrain();

    $display("[TB] back-pressure");
    accepted = 0;
    validIn = 1'b1;
    for (int c = 0; c < 140; c++) begin
      v = 16'(c * 977 - 20000);
      din = v;
      takeIt = readyIn;
      @(posedge clk); #1;
      if (takeIt) begin
        accepted++;
        expQ.push_back(modelPush(v));
      end
    end
    validIn = 1'b0;
    checkOutput("acceptedCount", accepted, 4);
    waitDrain();

    $display("[TB] reset mid-MAC");
    din = 16'sd1234; validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busyBeforeAbort", longint'(busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("abortValidOut", longint'(validOut), 0);
    checkOutput("abortDout", longint'(dout), 0);
    checkOutput("abortBusy", longint'(busy), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    modelClear();
    @(posedge clk); #1;
    checkOutput("readyAfterAbort", longint'(readyIn), 1);
    for (int n = 0; n < 40; n++)
      applyStimulus((n == 0) ? -16'sd32768 : 16'sd0, 1'b1, longint'(-32768) * longint'(coef[n]));
    waitDrain();

    $display("[TB] delay-line wrap with random samples");
    for (int n = 0; n < 100; n++) applyStimulus(16'($urandom), 1'b0, 0);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
